// File: rtl/hwpe_ctrl_package.sv
// ---------------------------------------------------------------------------
// hwpe_ctrl_package: shared types for the HWPE control block.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hwpe_ctrl_package;

  localparam int unsigned REGFILE_N_CONTEXT = 2;

  // Context index width, at least one bit even for a single context.
  function automatic int unsigned ctx_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned REGFILE_LOG_CTX = ctx_idx_width(REGFILE_N_CONTEXT);

  typedef enum logic [3:0] {
    CTX_IDLE  = 4'b0001,
    CTX_START = 4'b0010,
    CTX_RUN   = 4'b0100,
    CTX_DONE  = 4'b1000
  } ctx_sched_state_t;

  typedef struct packed {
    logic                       is_trigger;
    logic                       true_done;
    logic [REGFILE_LOG_CTX-1:0] pointer_context;
    logic [REGFILE_LOG_CTX-1:0] running_context;
    logic                       full_context;
    logic                       is_critical;
  } flags_regfile_t;

endpackage

`default_nettype wire

// File: rtl/hwpe_ctrl_ctx_scheduler.sv
// ---------------------------------------------------------------------------
// hwpe_ctrl_ctx_scheduler: offload lock, context FIFO and engine sequencing.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hwpe_ctrl_ctx_scheduler
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned N_CONTEXT = REGFILE_N_CONTEXT,
  parameter int unsigned ID_WIDTH  = 16,
  parameter int unsigned LOG_CTX   = ctx_idx_width(N_CONTEXT)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                acquire_i,
  input  logic [ID_WIDTH-1:0] acquire_src_i,
  input  logic                trigger_i,
  input  logic [ID_WIDTH-1:0] trigger_src_i,
  input  logic                engine_done_i,
  output logic                is_critical_o,
  output logic                full_context_o,
  output logic [LOG_CTX-1:0]  pointer_context_o,
  output logic [LOG_CTX-1:0]  running_context_o,
  output logic                is_trigger_o,
  output logic                engine_start_o,
  output logic                true_done_o,
  output logic                busy_o
);

  localparam logic [LOG_CTX:0]   CNT_FULL = (LOG_CTX+1)'(N_CONTEXT);
  localparam logic [LOG_CTX-1:0] CTX_LAST = LOG_CTX'(N_CONTEXT - 1);

  ctx_sched_state_t    state_q, state_d;
  logic [LOG_CTX:0]    cnt_q, cnt_d;
  logic [LOG_CTX-1:0]  ptr_q, ptr_d, run_q, run_d;
  logic                lock_q, lock_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic                acq_grant, trig_accept, job_retire;

  // An accepted trigger releases the lock, so a same-cycle acquire sees it held.
  assign trig_accept = trigger_i & lock_q & (trigger_src_i == owner_q);
  assign acq_grant   = acquire_i & ~lock_q & (cnt_q < CNT_FULL);
  assign job_retire  = (state_q == CTX_DONE);

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    if (trig_accept) begin
      lock_d = 1'b0;
    end else if (acq_grant) begin
      lock_d  = 1'b1;
      owner_d = acquire_src_i;
    end

    ptr_d = ptr_q;
    if (trig_accept) ptr_d = (ptr_q == CTX_LAST) ? '0 : ptr_q + LOG_CTX'(1);
    run_d = run_q;
    if (job_retire)  run_d = (run_q == CTX_LAST) ? '0 : run_q + LOG_CTX'(1);

    case ({trig_accept, job_retire})
      2'b10:   cnt_d = cnt_q + (LOG_CTX+1)'(1);
      2'b01:   cnt_d = cnt_q - (LOG_CTX+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    engine_start_o = 1'b0;
    true_done_o    = 1'b0;
    case (state_q)
      CTX_IDLE:  if (cnt_q != '0) state_d = CTX_START;
      CTX_START: begin
        engine_start_o = 1'b1;
        state_d        = CTX_RUN;
      end
      CTX_RUN:   if (engine_done_i) state_d = CTX_DONE;
      CTX_DONE: begin
        true_done_o = 1'b1;
        state_d     = CTX_IDLE;
      end
      default:   state_d = CTX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CTX_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      run_q   <= '0;
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else if (clear_i) begin
      state_q <= CTX_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      run_q   <= '0;
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      run_q   <= run_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end

  assign is_critical_o     = lock_q;
  assign full_context_o    = (cnt_q == CNT_FULL);
  assign pointer_context_o = ptr_q;
  assign running_context_o = run_q;
  assign is_trigger_o      = trig_accept;
  assign busy_o            = (cnt_q != '0) | (state_q != CTX_IDLE);

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CNT_FULL);
  a_start_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
    engine_start_o |=> !engine_start_o);
  a_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
    true_done_o |=> !true_done_o);

endmodule

`default_nettype wire

// File: tb/tb_hwpe_ctrl_ctx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hwpe_ctrl_ctx_scheduler: directed bench with a cycle-level reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hwpe_ctrl_ctx_scheduler;

  localparam int NCTX = 2;
  localparam int LOGC = 1;
  localparam int IDW  = 16;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic acquire = 1'b0, trigger = 1'b0, done = 1'b0;
  logic [IDW-1:0] asrc = '0, tsrc = '0;

  logic crit, full, is_trig, start, tdone, busy;
  logic [LOGC-1:0] ptr, runc;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  hwpe_ctrl_ctx_scheduler #(.N_CONTEXT(NCTX), .ID_WIDTH(IDW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .clear_i          (clear),
    .acquire_i        (acquire),
    .acquire_src_i    (asrc),
    .trigger_i        (trigger),
    .trigger_src_i    (tsrc),
    .engine_done_i    (done),
    .is_critical_o    (crit),
    .full_context_o   (full),
    .pointer_context_o(ptr),
    .running_context_o(runc),
    .is_trigger_o     (is_trig),
    .engine_start_o   (start),
    .true_done_o      (tdone),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: lock/owner, job count, two ring indices and the
  // timestamps at which the current job must start and retire.
  bit             m_lock, m_job;
  logic [IDW-1:0] m_owner;
  int             m_cnt, m_ptr, m_run, m_start, m_retire, old_cnt;
  int             e_trig, e_start, e_tdone, e_busy;
  bit             grant;

  always @(negedge clk) begin
    if (!rst_n || clear) begin
      if (rst_n) begin
        chk("m_crit", 32'(crit), 32'(m_lock));
        chk("m_busy_clr", 32'(busy), 32'((m_cnt != 0) || (m_job && cyc >= m_start)));
      end
      m_lock = 0; m_owner = '0; m_cnt = 0; m_ptr = 0; m_run = 0;
      m_job = 0; m_start = -1; m_retire = -1;
    end else begin
      e_trig  = (trigger && m_lock && tsrc == m_owner) ? 1 : 0;
      e_start = (m_job && cyc == m_start) ? 1 : 0;
      e_tdone = (m_job && cyc == m_retire) ? 1 : 0;
      e_busy  = ((m_cnt != 0) || (m_job && cyc >= m_start)) ? 1 : 0;
      chk("m_crit",  32'(crit),    32'(m_lock));
      chk("m_full",  32'(full),    32'(m_cnt == NCTX));
      chk("m_ptr",   32'(ptr),     32'(m_ptr));
      chk("m_run",   32'(runc),    32'(m_run));
      chk("m_trig",  32'(is_trig), 32'(e_trig));
      chk("m_start", 32'(start),   32'(e_start));
      chk("m_tdone", 32'(tdone),   32'(e_tdone));
      chk("m_busy",  32'(busy),    32'(e_busy));

      grant   = acquire && !m_lock && (m_cnt < NCTX);
      old_cnt = m_cnt;
      m_cnt   = m_cnt + e_trig - e_tdone;
      if (e_trig != 0) m_lock = 0;
      else if (grant) begin
        m_lock  = 1;
        m_owner = asrc;
      end
      m_ptr = (m_ptr + e_trig) % NCTX;
      m_run = (m_run + e_tdone) % NCTX;
      if (e_tdone != 0) m_job = 0;
      else if (!m_job && old_cnt > 0) begin
        m_job = 1; m_start = cyc + 1; m_retire = -1;
      end else if (m_job && cyc > m_start && m_retire < 0 && done) begin
        m_retire = cyc + 1;
      end
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
    acquire = 0; trigger = 0; done = 0; clear = 0;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    neg();
    chk("rst_crit", 32'(crit), 0);   chk("rst_full", 32'(full), 0);
    chk("rst_ptr", 32'(ptr), 0);     chk("rst_run", 32'(runc), 0);
    chk("rst_start", 32'(start), 0); chk("rst_tdone", 32'(tdone), 0);
    chk("rst_busy", 32'(busy), 0);   chk("rst_trig", 32'(is_trig), 0);
    @(posedge clk); #1; rst_n = 1;

    // engine_done while idle is ignored
    done = 1; neg(); chk("idle_done_tdone", 32'(tdone), 0); nxt();
    neg(); chk("idle_done_busy", 32'(busy), 0); chk("idle_done_tdone2", 32'(tdone), 0); nxt();

    // acquire + trigger from core 3, start two cycles after trigger
    acquire = 1; asrc = 3; neg(); chk("acq1_crit_pre", 32'(crit), 0); nxt();
    trigger = 1; tsrc = 3; neg();
    chk("acq1_crit_post", 32'(crit), 1); chk("trig1_accept", 32'(is_trig), 1); nxt();
    neg(); chk("trig1_ptr", 32'(ptr), 1); chk("trig1_unlock", 32'(crit), 0);
    chk("trig1_start_t1", 32'(start), 0); chk("trig1_busy", 32'(busy), 1); nxt();
    neg(); chk("trig1_start_t2", 32'(start), 1); nxt();
    neg(); chk("trig1_start_t3", 32'(start), 0); nxt();

    // second requester sees lock held; non-owner trigger ignored
    acquire = 1; asrc = 3; neg(); chk("acq2_crit_pre", 32'(crit), 0); nxt();
    acquire = 1; asrc = 5; neg(); chk("acq5_sees_lock", 32'(crit), 1); chk("acq5_full", 32'(full), 0); nxt();
    trigger = 1; tsrc = 5; neg(); chk("trig5_reject", 32'(is_trig), 0); nxt();
    trigger = 1; tsrc = 3; neg(); chk("lock_held", 32'(crit), 1); chk("trig3_accept", 32'(is_trig), 1); nxt();
    neg(); chk("fill_full", 32'(full), 1); chk("fill_ptr_wrap", 32'(ptr), 0); chk("fill_unlock", 32'(crit), 0); nxt();

    // third acquire refused when full; retire first job
    acquire = 1; asrc = 7; neg(); chk("acq7_full", 32'(full), 1); chk("acq7_crit", 32'(crit), 0); nxt();
    done = 1; neg(); chk("acq7_refused", 32'(crit), 0); chk("done1_tdone_t0", 32'(tdone), 0); nxt();
    neg(); chk("done1_tdone_t1", 32'(tdone), 1); chk("done1_run_pre", 32'(runc), 0); nxt();
    neg(); chk("done1_run", 32'(runc), 1); chk("done1_notfull", 32'(full), 0);
    chk("done1_busy", 32'(busy), 1); chk("job2_start_t0", 32'(start), 0); nxt();
    neg(); chk("job2_start", 32'(start), 1); nxt();

    // trigger accepted in the retire cycle: count unchanged, both indices advance
    acquire = 1; asrc = 3; nxt();
    done = 1; nxt();
    trigger = 1; tsrc = 3; neg(); chk("co_tdone", 32'(tdone), 1); chk("co_trig", 32'(is_trig), 1); nxt();
    neg(); chk("co_ptr", 32'(ptr), 1); chk("co_run_wrap", 32'(runc), 0);
    chk("co_cnt_notfull", 32'(full), 0); chk("co_cnt_busy", 32'(busy), 1); nxt();
    neg(); chk("job3_start", 32'(start), 1); nxt();

    // clear while running with two contexts queued
    acquire = 1; asrc = 3; nxt();
    trigger = 1; tsrc = 3; nxt();
    clear = 1; neg(); chk("clr_pre_full", 32'(full), 1); chk("clr_pre_busy", 32'(busy), 1); nxt();
    neg(); chk("clr_busy", 32'(busy), 0); chk("clr_full", 32'(full), 0);
    chk("clr_ptr", 32'(ptr), 0); chk("clr_run", 32'(runc), 0); chk("clr_crit", 32'(crit), 0); nxt();
    done = 1; neg(); chk("clr_done_tdone", 32'(tdone), 0); nxt();
    neg(); chk("clr_done_tdone2", 32'(tdone), 0); chk("clr_start", 32'(start), 0);
    chk("clr_idle_busy", 32'(busy), 0); nxt();
    repeat (2) nxt();

    // full job after clear with a wide requester id
    acquire = 1; asrc = 16'hBEEF; nxt();
    trigger = 1; tsrc = 16'hBEEF; neg(); chk("beef_trig", 32'(is_trig), 1); nxt();
    nxt();
    neg(); chk("beef_start", 32'(start), 1); nxt();
    nxt();
    done = 1; nxt();
    neg(); chk("beef_tdone", 32'(tdone), 1); chk("beef_ptr", 32'(ptr), 1); nxt();
    neg(); chk("beef_run", 32'(runc), 1); chk("beef_idle", 32'(busy), 0); nxt();
    repeat (3) nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
